// File: rtl/speck_decrypt_sequencer_if.sv
// Host-side request/response bus of the SPECK128/128 decrypt sequencer.
//   start      : one-cycle request (host -> sequencer)
//   key        : 128-bit master key, captured with an accepted start
//   ciphertext : 128-bit block to decrypt, captured with an accepted start
//   plaintext  : result, valid while done is high, held until the next accept
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   error      : one-cycle pulse with done when an engine step timed out
interface speck_decrypt_sequencer_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    output start, key, ciphertext,
    input  plaintext, busy, done, error
  );

  modport slave (
    input  start, key, ciphertext,
    output plaintext, busy, done, error
  );
endinterface

// File: rtl/speck_decrypt_sequencer.sv
// Iterative SPECK128/128 decryption controller. Drives one shared key
// schedule engine to fill a subkey store, then drives one shared round
// decrypt engine over the store in reverse order, chaining each round's
// output into the next round. The last expanded key is cached so a repeat
// of the same key skips the key schedule.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   host          : start/key/ciphertext in, plaintext/busy/done/error out
//   ks_*          : key schedule engine (start, key, round ctr / finished, subkey)
//   rd_*          : round engine (start, subkey, ciphertext / finished, plaintext)
module speck_decrypt_sequencer #(
  parameter int unsigned NR_ROUNDS = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  speck_decrypt_sequencer_if.slave      host,
  output logic                          ks_start,
  output logic [127:0]                  ks_key,
  output logic [63:0]                   ks_round_ctr,
  input  logic                          ks_finished,
  input  logic [127:0]                  ks_subkey,
  output logic                          rd_start,
  output logic [63:0]                   rd_subkey,
  output logic [127:0]                  rd_ciphertext,
  input  logic                          rd_finished,
  input  logic [127:0]                  rd_plaintext
);
  localparam int unsigned IW = $clog2(NR_ROUNDS);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_I    = IW'(NR_ROUNDS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, KS_START, KS_WAIT, KS_STORE, RD_START, RD_WAIT, RD_STORE, DONE
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  i;
  logic [WW-1:0]  wait_cnt;
  logic           qual;
  logic           key_valid;
  logic [127:0]   cached_key, prev_key, data_reg, key_q, ct_q, plain_q;
  logic           err_q;
  logic [63:0]    store [NR_ROUNDS];

  logic accept, cache_hit, ks_store, rd_store, abort, wait_miss;
  logic busy, done, error;

  assign cache_hit      = key_valid && (host.key == cached_key);
  assign host.busy      = busy;
  assign host.done      = done;
  assign host.error     = error;
  assign host.plaintext = plain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    ks_start      = 1'b0;
    ks_key        = '0;
    ks_round_ctr  = '0;
    rd_start      = 1'b0;
    rd_subkey     = '0;
    rd_ciphertext = '0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    accept        = 1'b0;
    ks_store      = 1'b0;
    rd_store      = 1'b0;
    abort         = 1'b0;
    wait_miss     = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          accept     = 1'b1;
          state_next = cache_hit ? RD_START : KS_START;
        end
      end
      KS_START, KS_WAIT: begin
        busy         = 1'b1;
        ks_start     = (state == KS_START);
        ks_key       = (i == '0) ? key_q : prev_key;
        ks_round_ctr = 64'(i);
        if (state == KS_START) begin
          state_next = KS_WAIT;
        end else if (qual) begin
          // first wait cycle is skipped (qual=0) to ignore a stale finished level
          if (ks_finished)               state_next = KS_STORE;
          else if (wait_cnt == LAST_WAIT) begin
            abort      = 1'b1;
            state_next = DONE;
          end else                        wait_miss  = 1'b1;
        end
      end
      KS_STORE: begin
        busy       = 1'b1;
        ks_store   = 1'b1;
        state_next = (i == LAST_I) ? RD_START : KS_START;
      end
      RD_START, RD_WAIT: begin
        busy          = 1'b1;
        rd_start      = (state == RD_START);
        rd_subkey     = store[LAST_I - i];
        rd_ciphertext = (i == '0) ? ct_q : data_reg;
        if (state == RD_START) begin
          state_next = RD_WAIT;
        end else if (qual) begin
          if (rd_finished)               state_next = RD_STORE;
          else if (wait_cnt == LAST_WAIT) begin
            abort      = 1'b1;
            state_next = DONE;
          end else                        wait_miss  = 1'b1;
        end
      end
      RD_STORE: begin
        busy       = 1'b1;
        rd_store   = 1'b1;
        state_next = (i == LAST_I) ? DONE : RD_START;
      end
      DONE: begin
        done       = 1'b1;
        error      = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i          <= '0;
      wait_cnt   <= '0;
      qual       <= 1'b0;
      key_valid  <= 1'b0;
      cached_key <= '0;
      prev_key   <= '0;
      data_reg   <= '0;
      key_q      <= '0;
      ct_q       <= '0;
      plain_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        key_q   <= host.key;
        ct_q    <= host.ciphertext;
        i       <= '0;
        err_q   <= 1'b0;
        plain_q <= '0;
        if (!cache_hit) key_valid <= 1'b0;
      end
      if (state == KS_START || state == RD_START) begin
        wait_cnt <= '0;
        qual     <= 1'b0;
      end else if (wait_miss) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == KS_WAIT || state == RD_WAIT) qual <= 1'b1;
      if (ks_store) begin
        prev_key <= ks_subkey;
        if (i == LAST_I) begin
          key_valid  <= 1'b1;
          cached_key <= key_q;
          i          <= '0;
        end else begin
          i <= i + 1'b1;
        end
      end
      if (rd_store) begin
        data_reg <= rd_plaintext;
        if (i == LAST_I) plain_q <= rd_plaintext;
        else             i       <= i + 1'b1;
      end
      if (abort) begin
        // a partly filled store must never be reused as a cache hit
        key_valid <= 1'b0;
        err_q     <= 1'b1;
        plain_q   <= data_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ks_store) store[i] <= ks_subkey[127:64];
  end
endmodule

// File: doc/speck_decrypt_sequencer.md
# speck_decrypt_sequencer

Iterative control block for SPECK128/128 decryption. It owns one shared `key_schedule` engine and one shared `round_decrypt` engine, and time-multiplexes them over all rounds. It expands the key into an internal subkey store, then feeds the rounds in reverse subkey order, chaining each round's output into the next round's input. It replaces the fully unrolled per-round instance array with a single start/done interface for the system.

## Interface
Parameters:
- `NR_ROUNDS`, default 32: number of rounds; also the subkey store depth.
- `TIMEOUT`, default 255: maximum number of qualified wait cycles allowed per engine step before the block aborts.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `key`  in  128  master key; latched on accepted `start`.
- `ciphertext`  in  128  block to decrypt; latched on accepted `start`.
- `plaintext`  out  128  result; valid while `done`=1.
- `busy`  out  1  high from the cycle after accept until the DONE state.
- `done`  out  1  one-cycle pulse in DONE.
- `error`  out  1  one-cycle pulse with `done` on timeout; `plaintext` is invalid when set.
- `ks_start`  out  1  start strobe to the key schedule engine.
- `ks_key`  out  128  key schedule input.
- `ks_round_ctr`  out  64  current round index.
- `ks_finished`  in  1  level from the engine.
- `ks_subkey`  in  128  engine output (outKey).
- `rd_start`  out  1  start strobe to the round engine.
- `rd_subkey`  out  64  round subkey.
- `rd_ciphertext`  out  128  round engine input.
- `rd_finished`  in  1  level from the engine.
- `rd_plaintext`  in  128  round engine output.

## Operation
- Reset values:
  - all outputs 0; state IDLE; `i`=0; wait counter 0.
  - `key_valid`=0, `cached_key`=0, `prev_key`=0, `data_reg`=0.
  - Subkey store contents are don't-care.
- States: IDLE, KS_START, KS_WAIT, KS_STORE, RD_START, RD_WAIT, RD_STORE, DONE.
- IDLE: when `start`=1:
  - latch `key` and `ciphertext`; set `i`=0.
  - if `key_valid` and `key`==`cached_key`, go to RD_START (key schedule skipped).
  - otherwise clear `key_valid` and go to KS_START.
- KS_START:
  - `ks_start`=1 for exactly this cycle.
  - `ks_key` = latched key when `i`=0, else `prev_key`.
  - `ks_round_ctr` = `i`, zero-extended.
  - go to KS_WAIT.
- KS_WAIT:
  - `ks_key` and `ks_round_ctr` are held.
  - The first WAIT cycle is unqualified: `ks_finished` is ignored there, to mask a stale level.
  - From the second cycle on, `ks_finished`=1 moves to KS_STORE.
  - Each qualified cycle without `finished` increments the wait counter. Reaching `TIMEOUT` goes to DONE with `error`.
- KS_STORE:
  - `store[i]` ← `ks_subkey[127:64]`; `prev_key` ← `ks_subkey`.
  - if `i`=`NR_ROUNDS`-1: set `key_valid`, `cached_key` ← latched key, `i`=0, go to RD_START.
  - else `i`+1 and go to KS_START.
  - Wait counter clears on every START state.
- RD_START:
  - `rd_start`=1 for one cycle.
  - `rd_subkey` = `store[NR_ROUNDS-1-i]`.
  - `rd_ciphertext` = latched ciphertext when `i`=0, else `data_reg`.
- RD_WAIT: same qualification and timeout rules as KS_WAIT, using `rd_finished`.
- RD_STORE:
  - `data_reg` ← `rd_plaintext`.
  - if `i`=`NR_ROUNDS`-1, go to DONE; else `i`+1 and go to RD_START.
- DONE:
  - `done`=1 and `plaintext`=`data_reg`; `busy`=0.
  - return to IDLE next cycle.
  - `plaintext` holds its value until the next accepted `start`.
- Timeout abort clears `key_valid`, so a partially filled store is never reused.
- `start` while busy is ignored and not queued.
- Reset mid-operation: returns to IDLE immediately, with all reset values above.
- `i` is `$clog2(NR_ROUNDS)` bits wide. It never wraps: the terminal compare occurs before increment.

## Timing
- Accept: `start` sampled at edge T; KS_START (or RD_START) is active in cycle T+1.
- One step with an ideal engine (`finished` high by the first qualified cycle) takes 4 cycles: START, WAIT (unqualified), WAIT (hit), STORE.
- Full run latency from accept to `done`, ideal engines: 8·`NR_ROUNDS`+1 cycles, i.e. 257 for 32 rounds.
- Key-cache hit: 4·`NR_ROUNDS`+1 cycles, i.e. 129.
- Each extra engine wait cycle adds 1 cycle per step.
- `ks_start` and `rd_start` are never high at the same time, and never high in two consecutive cycles.

## Test plan
- Reset, then one decrypt with behavioural engines: `key`=0x0f0e0d0c0b0a09080706050403020100, `ciphertext`=0xa65d9851797832657860fedf5c570d18 → `done` after 257 cycles with `plaintext`=0x6c617669757165207469206564616d20 and `error`=0.
- Same key, new ciphertext immediately after → no `ks_start` pulses; `done` after 129 cycles with the correct plaintext.
- Round engine stalls 5 extra cycles at round 7 → latency 262 and the result is unchanged.
- `rd_finished` tied low with `TIMEOUT`=3 → `done` and `error` pulse together; the next run with the same key re-runs the key schedule (32 `ks_start` pulses).
- `start` pulsed at cycle 50 of a run → ignored; exactly one `done` occurs.
- `rst_n` low during round 12 → all outputs 0 asynchronously; the next run with the same key performs a full key schedule.
